// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alarm_pkg
// Description : Shared definitions for the keypad scanner: matrix size,
//               scanner FSM state encodings, sweep classification and
//               small column-decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package alarm_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } kp_state_t;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_SINGLE = 2'd1,
    CLS_MULTI  = 2'd2
  } sweep_class_t;

  // Number of asserted bits in a 4-bit column vector.
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  // Index of the lowest asserted bit (only meaningful for one-hot input).
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_sweep.sv
`default_nettype none
// ============================================================================
// Module      : keypad_sweep
// Description : Row driver, settle counter and per-sweep classifier.
//               Drives one row low at a time (0..3), holds each row for
//               SETTLE_CYC+1 cycles and samples the columns in the last
//               cycle. After the row-3 sample a one-cycle done pulse is
//               raised together with the class and code of the sweep.
// Ports       : clk2      - scan clock
//               reset     - asynchronous active-low reset
//               i_col_n   - column inputs, active-low
//               o_row_n   - row drive, active-low one-hot
//               o_done    - one-cycle pulse per completed sweep
//               o_class   - NONE / SINGLE / MULTI for the finished sweep
//               o_code    - {row,col} of the single key (valid with SINGLE)
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_sweep
  import alarm_pkg::*;
#(
  parameter int SETTLE_CYC = 1
) (
  input  logic                clk2,
  input  logic                reset,
  input  logic [NUM_COLS-1:0] i_col_n,
  output logic [NUM_ROWS-1:0] o_row_n,
  output logic                o_done,
  output sweep_class_t        o_class,
  output logic [3:0]          o_code
);

  localparam int SET_W = ($clog2(SETTLE_CYC + 1) < 1) ? 1 : $clog2(SETTLE_CYC + 1);

  logic [SET_W-1:0] r_settle;
  logic [1:0]       r_row;
  logic [1:0]       r_acc_cnt;   // 0 = none, 1 = single, 2 = multi (saturates)
  logic [3:0]       r_acc_code;
  logic             r_done;
  sweep_class_t     r_class;
  logic [3:0]       r_code;

  logic             w_sample;
  logic [3:0]       w_low;
  logic [2:0]       w_row_cnt;
  logic [1:0]       w_base_cnt;
  logic [3:0]       w_base_code;
  logic [1:0]       w_sum_cnt;
  logic [3:0]       w_sum_code;

  assign w_sample  = (r_settle == SET_W'(SETTLE_CYC));
  assign w_low     = ~i_col_n;
  assign w_row_cnt = popcount4(w_low);

  // Row 0 starts a fresh sweep, so earlier accumulation is discarded there.
  always_comb begin
    w_base_cnt  = (r_row == 2'd0) ? 2'd0 : r_acc_cnt;
    w_base_code = (r_row == 2'd0) ? 4'd0 : r_acc_code;
    w_sum_cnt   = w_base_cnt;
    w_sum_code  = w_base_code;
    if (w_row_cnt == 3'd1 && w_base_cnt == 2'd0) begin
      w_sum_cnt  = 2'd1;
      w_sum_code = {r_row, low_index(w_low)};
    end else if (w_row_cnt != 3'd0) begin
      w_sum_cnt  = 2'd2;
    end
  end

  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset) begin
      r_settle   <= '0;
      r_row      <= 2'd0;
      r_acc_cnt  <= 2'd0;
      r_acc_code <= 4'd0;
      r_done     <= 1'b0;
      r_class    <= CLS_NONE;
      r_code     <= 4'd0;
    end else begin
      r_done <= 1'b0;
      if (w_sample) begin
        r_settle   <= '0;
        r_row      <= r_row + 2'd1;
        r_acc_cnt  <= w_sum_cnt;
        r_acc_code <= w_sum_code;
        if (r_row == 2'd3) begin
          r_done  <= 1'b1;
          r_code  <= w_sum_code;
          r_class <= (w_sum_cnt == 2'd0) ? CLS_NONE :
                     (w_sum_cnt == 2'd1) ? CLS_SINGLE : CLS_MULTI;
        end
      end else begin
        r_settle <= r_settle + SET_W'(1);
      end
    end
  end

  assign o_row_n = ~(NUM_ROWS'(1) << r_row);
  assign o_done  = r_done;
  assign o_class = r_class;
  assign o_code  = r_code;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : 4x4 matrix keypad scanner with sweep-level debounce of press
//               and release, and optional auto-repeat while a key is held.
// Ports       : clk2       - scan clock
//               reset      - asynchronous active-low reset
//               col_n      - matrix columns, active-low
//               repeat_en  - enable auto-repeat while held
//               row_n      - row drive, active-low one-hot
//               key_code   - last accepted key {row,col}
//               key_valid  - one-cycle pulse per press / repeat event
//               key_held   - high while a debounced key is held
//               key_strobe - per-row pulse for column-3 (function) keys
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
  import alarm_pkg::*;
#(
  parameter int SETTLE_CYC  = 1,
  parameter int DEBOUNCE_N  = 2,
  parameter int REPEAT_DLY  = 12,
  parameter int REPEAT_RATE = 3
) (
  input  logic       clk2,
  input  logic       reset,
  input  logic [3:0] col_n,
  input  logic       repeat_en,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [3:0] key_strobe
);

  localparam int DB_W    = ($clog2(DEBOUNCE_N + 1) < 1) ? 1 : $clog2(DEBOUNCE_N + 1);
  localparam int REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int REP_W   = ($clog2(REP_MAX + 1) < 1) ? 1 : $clog2(REP_MAX + 1);

  logic         w_done;
  sweep_class_t w_class;
  logic [3:0]   w_code;

  keypad_sweep #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_sweep (
    .clk2    (clk2),
    .reset   (reset),
    .i_col_n (col_n),
    .o_row_n (row_n),
    .o_done  (w_done),
    .o_class (w_class),
    .o_code  (w_code)
  );

  kp_state_t        r_state,     w_state_nxt;
  logic [DB_W-1:0]  r_db_cnt,    w_db_nxt;
  logic [3:0]       r_cand,      w_cand_nxt;
  logic [REP_W-1:0] r_rep_cnt,   w_rep_nxt;
  logic             r_rep_armed, w_armed_nxt;   // first repeat already issued
  logic [3:0]       r_key_code,  w_code_nxt;
  logic             r_key_held,  w_held_nxt;
  logic             r_key_valid;
  logic [3:0]       r_key_strobe;

  logic             w_fire;
  logic             w_single;
  logic             w_same;
  logic [DB_W-1:0]  w_db_inc;
  logic [REP_W-1:0] w_rep_inc;
  logic [3:0]       w_strobe_nxt;

  assign w_single  = (w_class == CLS_SINGLE);
  assign w_same    = w_single && (w_code == r_cand);
  assign w_db_inc  = (r_db_cnt == DB_W'(DEBOUNCE_N)) ? r_db_cnt : r_db_cnt + DB_W'(1);
  assign w_rep_inc = (r_rep_cnt == REP_W'(REP_MAX)) ? r_rep_cnt : r_rep_cnt + REP_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_db_nxt    = r_db_cnt;
    w_cand_nxt  = r_cand;
    w_rep_nxt   = r_rep_cnt;
    w_armed_nxt = r_rep_armed;
    w_code_nxt  = r_key_code;
    w_held_nxt  = r_key_held;
    w_fire      = 1'b0;

    if (w_done) begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_single) begin
            w_cand_nxt = w_code;
            if (DEBOUNCE_N <= 1) begin
              w_state_nxt = ST_HELD;
              w_db_nxt    = '0;
              w_code_nxt  = w_code;
              w_held_nxt  = 1'b1;
              w_fire      = 1'b1;
            end else begin
              w_state_nxt = ST_PRESS_DB;
              w_db_nxt    = DB_W'(1);
            end
          end
        end

        ST_PRESS_DB: begin
          if (w_same) begin
            w_db_nxt = w_db_inc;
            if (w_db_inc >= DB_W'(DEBOUNCE_N)) begin
              w_state_nxt = ST_HELD;
              w_db_nxt    = '0;
              w_code_nxt  = r_cand;
              w_held_nxt  = 1'b1;
              w_rep_nxt   = '0;
              w_armed_nxt = 1'b0;
              w_fire      = 1'b1;
            end
          end else if (w_single) begin
            w_cand_nxt = w_code;
            w_db_nxt   = DB_W'(1);
          end else begin
            w_state_nxt = ST_IDLE;
            w_db_nxt    = '0;
          end
        end

        ST_HELD: begin
          if (w_same) begin
            if (!repeat_en) begin
              w_rep_nxt   = '0;
              w_armed_nxt = 1'b0;
            end else if ((!r_rep_armed && w_rep_inc == REP_W'(REPEAT_DLY)) ||
                         ( r_rep_armed && w_rep_inc == REP_W'(REPEAT_RATE))) begin
              w_fire      = 1'b1;
              w_rep_nxt   = '0;
              w_armed_nxt = 1'b1;
            end else begin
              w_rep_nxt = w_rep_inc;
            end
          end else begin
            w_rep_nxt   = '0;
            w_armed_nxt = 1'b0;
            if (DEBOUNCE_N <= 1) begin
              w_state_nxt = ST_IDLE;
              w_db_nxt    = '0;
              w_held_nxt  = 1'b0;
            end else begin
              w_state_nxt = ST_RELEASE_DB;
              w_db_nxt    = DB_W'(1);
            end
          end
        end

        ST_RELEASE_DB: begin
          if (w_same) begin
            // Bounce during release: resume holding without a new event.
            w_state_nxt = ST_HELD;
            w_db_nxt    = '0;
          end else begin
            w_db_nxt = w_db_inc;
            if (w_db_inc >= DB_W'(DEBOUNCE_N)) begin
              w_state_nxt = ST_IDLE;
              w_db_nxt    = '0;
              w_held_nxt  = 1'b0;
            end
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
          w_db_nxt    = '0;
        end
      endcase
    end

    // Function keys live in column 3; the strobe bit selects their row.
    w_strobe_nxt = 4'd0;
    if (w_fire && w_code_nxt[1:0] == 2'b11) begin
      w_strobe_nxt = 4'b0001 << w_code_nxt[3:2];
    end
  end

  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_db_cnt     <= '0;
      r_cand       <= 4'd0;
      r_rep_cnt    <= '0;
      r_rep_armed  <= 1'b0;
      r_key_code   <= 4'd0;
      r_key_held   <= 1'b0;
      r_key_valid  <= 1'b0;
      r_key_strobe <= 4'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_db_cnt     <= w_db_nxt;
      r_cand       <= w_cand_nxt;
      r_rep_cnt    <= w_rep_nxt;
      r_rep_armed  <= w_armed_nxt;
      r_key_code   <= w_code_nxt;
      r_key_held   <= w_held_nxt;
      r_key_valid  <= w_fire;
      r_key_strobe <= w_strobe_nxt;
    end
  end

  assign key_code   = r_key_code;
  assign key_valid  = r_key_valid;
  assign key_held   = r_key_held;
  assign key_strobe = r_key_strobe;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Directed self-checking bench for keypad_scanner. A small
//               matrix model pulls columns low for pressed keys on the
//               driven row; a monitor timestamps key_valid pulses in clock
//               edges counted from reset release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  logic        clk2;
  logic        reset;
  logic [3:0]  col_n;
  logic        repeat_en;
  logic [3:0]  row_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [3:0]  key_strobe;

  logic [15:0] keys;       // bit {row,col} set = key pressed
  int          pcount;     // rising edges since reset release
  int          pulse_t[$];
  logic [3:0]  last_code;
  logic [3:0]  last_strobe;
  int          tests;
  int          fails;

  keypad_scanner dut (
    .clk2       (clk2),
    .reset      (reset),
    .col_n      (col_n),
    .repeat_en  (repeat_en),
    .row_n      (row_n),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_held   (key_held),
    .key_strobe (key_strobe)
  );

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
      end
    end
  end

  always @(posedge clk2) pcount = pcount + 1;

  always @(negedge clk2) begin
    if (key_valid === 1'b1) begin
      pulse_t.push_back(pcount);
      last_code   = key_code;
      last_strobe = key_strobe;
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk2);
    reset = 1'b1;
    pcount = 0;
    pulse_t.delete();
  endtask

  task automatic test_reset();
    logic [3:0] exp_rows [8];
    exp_rows = '{4'b1110, 4'b1101, 4'b1101, 4'b1011,
                 4'b1011, 4'b0111, 4'b0111, 4'b1110};
    keys = 16'h0;
    reset = 1'b0;
    repeat (2) @(negedge clk2);
    tests++;
    if (row_n !== 4'b1110) begin
      fails++; $display("FAIL reset_row_n: got %b expected 1110", row_n);
    end
    tests++;
    if ({key_code, key_valid, key_held, key_strobe} !== 10'd0) begin
      fails++;
      $display("FAIL reset_outputs: code=%b valid=%b held=%b strobe=%b expected all 0",
               key_code, key_valid, key_held, key_strobe);
    end
    reset = 1'b1;
    pcount = 0;
    pulse_t.delete();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk2);
      tests++;
      if (row_n !== exp_rows[k]) begin
        fails++;
        $display("FAIL row_seq[%0d]: got %b expected %b", k + 1, row_n, exp_rows[k]);
      end
    end
  endtask

  task automatic test_single_press();
    keys = 16'h0;
    keys[11] = 1'b1;                      // row 2, column 3
    repeat_en = 1'b0;
    do_reset();
    repeat (16) @(negedge clk2);
    tests++;
    if (key_held !== 1'b0) begin
      fails++; $display("FAIL single_held_early: got %b expected 0", key_held);
    end
    @(negedge clk2);
    tests++;
    if (key_held !== 1'b1) begin
      fails++; $display("FAIL single_held_at17: got %b expected 1", key_held);
    end
    repeat (23) @(negedge clk2);
    tests++;
    if (pulse_t.size() !== 1 || (pulse_t.size() > 0 && pulse_t[0] !== 17)) begin
      fails++;
      $display("FAIL single_pulse: count=%0d first=%0d expected count 1 at 17",
               pulse_t.size(), (pulse_t.size() > 0) ? pulse_t[0] : -1);
    end
    tests++;
    if (last_code !== 4'b1011 || last_strobe !== 4'b0100 || key_code !== 4'b1011) begin
      fails++;
      $display("FAIL single_code: pulse_code=%b strobe=%b key_code=%b expected 1011/0100/1011",
               last_code, last_strobe, key_code);
    end
  endtask

  task automatic test_bounce();
    repeat_en = 1'b0;
    keys = 16'h0;
    do_reset();
    for (int s = 1; s <= 10; s++) begin
      keys = 16'h0;
      if (!(s <= 6 && (s % 2) == 0)) keys[6] = 1'b1;   // row 1, column 2
      repeat (8) @(negedge clk2);
      if (s == 6) begin
        tests++;
        if (pulse_t.size() !== 0) begin
          fails++; $display("FAIL bounce_quiet: got %0d pulses expected 0", pulse_t.size());
        end
      end
    end
    tests++;
    if (pulse_t.size() !== 1 || (pulse_t.size() > 0 && pulse_t[0] !== 65)) begin
      fails++;
      $display("FAIL bounce_pulse: count=%0d first=%0d expected count 1 at 65",
               pulse_t.size(), (pulse_t.size() > 0) ? pulse_t[0] : -1);
    end
    tests++;
    if (last_code !== 4'b0110 || last_strobe !== 4'b0000 || key_held !== 1'b1) begin
      fails++;
      $display("FAIL bounce_code: code=%b strobe=%b held=%b expected 0110/0000/1",
               last_code, last_strobe, key_held);
    end
  endtask

  task automatic test_multi();
    repeat_en = 1'b0;
    keys = 16'h0;
    keys[0] = 1'b1;
    keys[5] = 1'b1;
    do_reset();
    repeat (48) @(negedge clk2);
    tests++;
    if (pulse_t.size() !== 0 || key_held !== 1'b0 || key_code !== 4'd0) begin
      fails++;
      $display("FAIL multi_ignored: pulses=%0d held=%b code=%b expected 0/0/0000",
               pulse_t.size(), key_held, key_code);
    end
  endtask

  task automatic test_repeat();
    int exp_t [7];
    exp_t = '{17, 113, 137, 161, 185, 209, 233};
    keys = 16'h0;
    keys[15] = 1'b1;                      // row 3, column 3
    repeat_en = 1'b1;
    do_reset();
    repeat (244) @(negedge clk2);
    tests++;
    if (pulse_t.size() !== 7) begin
      fails++; $display("FAIL repeat_count: got %0d expected 7", pulse_t.size());
    end
    for (int i = 0; i < 7; i++) begin
      tests++;
      if (i >= pulse_t.size()) begin
        fails++; $display("FAIL repeat_time[%0d]: got none expected %0d", i, exp_t[i]);
      end else if (pulse_t[i] !== exp_t[i]) begin
        fails++; $display("FAIL repeat_time[%0d]: got %0d expected %0d", i, pulse_t[i], exp_t[i]);
      end
    end
    tests++;
    if (last_strobe !== 4'b1000 || last_code !== 4'b1111) begin
      fails++;
      $display("FAIL repeat_strobe: strobe=%b code=%b expected 1000/1111", last_strobe, last_code);
    end
    repeat_en = 1'b0;
    do_reset();
    repeat (244) @(negedge clk2);
    tests++;
    if (pulse_t.size() !== 1) begin
      fails++; $display("FAIL norepeat_count: got %0d expected 1", pulse_t.size());
    end
  endtask

  task automatic test_reset_midhold();
    keys = 16'h0;
    keys[11] = 1'b1;
    repeat_en = 1'b0;
    do_reset();
    repeat (27) @(negedge clk2);
    reset = 1'b0;
    #1;
    tests++;
    if (key_held !== 1'b0 || key_code !== 4'd0 || key_valid !== 1'b0 ||
        key_strobe !== 4'd0 || row_n !== 4'b1110) begin
      fails++;
      $display("FAIL midhold_reset: held=%b code=%b valid=%b strobe=%b row=%b expected 0/0000/0/0000/1110",
               key_held, key_code, key_valid, key_strobe, row_n);
    end
    @(negedge clk2);
    reset = 1'b1;
    pcount = 0;
    pulse_t.delete();
    repeat (40) @(negedge clk2);
    tests++;
    if (pulse_t.size() !== 1 || (pulse_t.size() > 0 && pulse_t[0] !== 17)) begin
      fails++;
      $display("FAIL midhold_recover: count=%0d first=%0d expected count 1 at 17",
               pulse_t.size(), (pulse_t.size() > 0) ? pulse_t[0] : -1);
    end
  endtask

  task automatic test_back_to_back();
    keys = 16'h0;
    keys[1] = 1'b1;                       // row 0, column 1
    repeat_en = 1'b0;
    do_reset();
    repeat (32) @(negedge clk2);
    keys = 16'h0;
    keys[2] = 1'b1;                       // row 0, column 2
    repeat (16) @(negedge clk2);
    tests++;
    if (key_held !== 1'b1) begin
      fails++; $display("FAIL switch_held_48: got %b expected 1", key_held);
    end
    @(negedge clk2);
    tests++;
    if (key_held !== 1'b0 || key_code !== 4'b0001) begin
      fails++;
      $display("FAIL switch_release_49: held=%b code=%b expected 0/0001", key_held, key_code);
    end
    repeat (24) @(negedge clk2);
    tests++;
    if (pulse_t.size() !== 2 || (pulse_t.size() == 2 && (pulse_t[0] !== 17 || pulse_t[1] !== 65))) begin
      fails++;
      $display("FAIL switch_pulses: count=%0d expected 2 at 17 and 65", pulse_t.size());
    end
    tests++;
    if (key_code !== 4'b0010 || last_code !== 4'b0010 || key_held !== 1'b1) begin
      fails++;
      $display("FAIL switch_code: key_code=%b pulse_code=%b held=%b expected 0010/0010/1",
               key_code, last_code, key_held);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    tests     = 0;
    fails     = 0;
    pcount    = 0;
    keys      = 16'h0;
    repeat_en = 1'b0;
    reset     = 1'b0;
    last_code   = 4'd0;
    last_strobe = 4'd0;
    test_reset();
    test_single_press();
    test_bounce();
    test_multi();
    test_repeat();
    test_reset_midhold();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
